// File: rtl/adder_bist_ctrl.sv
// Built-in self-test controller for half/ripple adders: walks every operand pair,
// waits a settle window, then checks {carry,sum} against a golden a+b.
module adder_bist_ctrl #(
    parameter int WIDTH  = 1,
    parameter int SETTLE = 1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    output logic [WIDTH-1:0]   a_out,
    output logic [WIDTH-1:0]   b_out,
    input  logic [WIDTH-1:0]   sum_in,
    input  logic               carry_in,
    output logic               busy,
    output logic               done,
    output logic               pass,
    output logic [2*WIDTH:0]   fail_count,
    output logic [WIDTH-1:0]   fail_a,
    output logic [WIDTH-1:0]   fail_b,
    output logic [WIDTH-1:0]   fail_sum,
    output logic               fail_carry
);

    localparam int VW = 2 * WIDTH;
    localparam int CW = 2 * WIDTH + 1;
    localparam logic [3:0]    SETTLE_LOAD = 4'(SETTLE - 1);
    localparam logic [VW-1:0] VEC_ONE     = VW'(1);
    localparam logic [CW-1:0] CNT_ONE     = CW'(1);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_SETTLE = 2'd1,
        S_CHECK  = 2'd2,
        S_DONE   = 2'd3
    } state_t;

    state_t          state;
    logic [VW-1:0]   vec;
    logic [3:0]      cnt;
    logic [WIDTH:0]  exp_res;
    logic            mismatch;
    logic            first_fail;

    assign a_out = vec[VW-1:WIDTH];
    assign b_out = vec[WIDTH-1:0];

    // Case-inequality so that X/Z from the adder under test counts as a failure.
    assign exp_res    = {1'b0, a_out} + {1'b0, b_out};
    assign mismatch   = ({carry_in, sum_in} !== exp_res);
    assign first_fail = mismatch && (fail_count == '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= S_IDLE;
            vec        <= '0;
            cnt        <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            pass       <= 1'b0;
            fail_count <= '0;
            fail_a     <= '0;
            fail_b     <= '0;
            fail_sum   <= '0;
            fail_carry <= 1'b0;
        end else begin
            case (state)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        state      <= S_SETTLE;
                        vec        <= '0;
                        cnt        <= SETTLE_LOAD;
                        busy       <= 1'b1;
                        done       <= 1'b0;
                        pass       <= 1'b0;
                        fail_count <= '0;
                        fail_a     <= '0;
                        fail_b     <= '0;
                        fail_sum   <= '0;
                        fail_carry <= 1'b0;
                    end
                end
                S_SETTLE: begin
                    if (cnt == 4'd0) begin
                        state <= S_CHECK;
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                S_CHECK: begin
                    if (mismatch) begin
                        fail_count <= fail_count + CNT_ONE;
                    end
                    if (first_fail) begin
                        fail_a     <= a_out;
                        fail_b     <= b_out;
                        fail_sum   <= sum_in;
                        fail_carry <= carry_in;
                    end
                    if (&vec) begin
                        // Vector stays on the last pair so the adder inputs hold in DONE.
                        state <= S_DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        pass  <= (fail_count == '0) && !mismatch;
                    end else begin
                        state <= S_SETTLE;
                        vec   <= vec + VEC_ONE;
                        cnt   <= SETTLE_LOAD;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: doc/adder_bist_ctrl.md
# adder_bist_ctrl

Synthesizable built-in self-test controller for the adder family in `Verilog_design_styles`. It performs in hardware what our adder benches do in simulation. It drives every operand pair into an adder under test, waits a settle window, samples the adder's sum and carry, and checks them against an internal golden model. It sits beside any half adder or ripple adder instance and reports pass/fail, a fail count and the first failing vector.

## Interface
Parameters:
- WIDTH, 1, operand width of the adder under test (1 = half adder); legal range 1–8.
- SETTLE, 1, cycles each vector is held before the check cycle; legal range 1–15.

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- rst_n  input  1  reset, asynchronous and active-low.
- start  input  1  begin a test run; sampled only in IDLE or DONE.
- a_out  output  WIDTH  operand a to the adder under test.
- b_out  output  WIDTH  operand b to the adder under test.
- sum_in  input  WIDTH  sum returned by the adder under test.
- carry_in  input  1  carry returned by the adder under test.
- busy  output  1  high while a run is in progress.
- done  output  1  high from run completion until the next start or reset.
- pass  output  1  valid with done; 1 when fail_count is 0.
- fail_count  output  2*WIDTH+1  number of mismatching vectors in the current or last run.
- fail_a, fail_b  output  WIDTH  operands of the first failing vector.
- fail_sum  output  WIDTH  sum_in captured at the first failure.
- fail_carry  output  1  carry_in captured at the first failure.

## Operation
- States: IDLE, SETTLE, CHECK, DONE.
- Vector counter vec is 2*WIDTH bits wide, with a_out = vec[2W-1:W] and b_out = vec[W-1:0]. Vectors run in ascending order: for WIDTH=1 the order is 00, 01, 10, 11.
- IDLE + start:
  - Clear vec, fail_count and all fail_* fields.
  - Load the settle counter with SETTLE-1.
  - Go to SETTLE with busy=1.
- SETTLE: if the counter is 0, go to CHECK; otherwise decrement the counter.
- CHECK:
  - Expected result is {carry,sum} = a_out + b_out, computed at WIDTH+1 bits with no truncation.
  - Mismatch when {carry_in,sum_in} differs from the expected value.
  - On a mismatch, increment fail_count. If fail_count was 0 before this check, also capture fail_a, fail_b, fail_sum and fail_carry.
  - If vec is all ones, go to DONE: busy=0, done=1, pass=(final fail_count==0).
  - Otherwise increment vec, reload the settle counter and go to SETTLE.
- DONE:
  - Outputs hold.
  - a_out and b_out hold the last vector.
  - start restarts exactly as from IDLE, clearing results and done.
- start while busy: ignored, and the run continues unaffected.
- fail_count cannot overflow: its maximum is 2^(2W), which fits in 2W+1 bits.
- X or Z on sum_in or carry_in counts as a mismatch (case-inequality compare).

## Timing
- Reset values: state=IDLE, a_out=0, b_out=0, busy=0, done=0, pass=0, fail_count=0, all fail_* fields 0.
- Reset asserted mid-run: all outputs take their reset values immediately (asynchronously). No run resumes after deassertion until a new start.
- Edge E0 samples start=1. From E0 onward, vector 0 is on a_out/b_out and busy=1.
- Each vector is held for SETTLE+1 cycles. Inputs are compared at the edge that ends the CHECK cycle, and the next vector appears at that same edge.
- Run length: 2^(2W)·(SETTLE+1) cycles from E0 to the edge that sets done.
- The adder under test is combinational and must settle within SETTLE cycles.

## Test plan
- WIDTH=1, SETTLE=1, correct half adder connected; pulse start:
  - done=1 and pass=1 exactly 8 cycles after the start edge.
  - fail_count=0.
  - a_out/b_out sequence 00, 01, 10, 11, each held 2 cycles.
- WIDTH=1, carry_in tied to 0; run:
  - fail_count=1, pass=0.
  - fail_a=1, fail_b=1, fail_sum=0, fail_carry=0.
- WIDTH=4, SETTLE=2, ripple adder with sum bit 0 inverted only when a=3 and b=5:
  - done after 768 cycles.
  - fail_count=1, fail_a=3, fail_b=5, fail_sum=9, fail_carry=0.
- WIDTH=1, start re-pulsed mid-run: ignored; done still arrives at cycle 8 with unchanged results.
- WIDTH=1, rst_n pulled low at cycle 3 of a run:
  - busy, done and all outputs drop to 0 immediately.
  - After release, a new start runs a full clean 8-cycle pass.
- WIDTH=1, start pulsed in DONE after a failing run:
  - fail_count, the fail_* fields and done clear at the start edge.
  - A now-correct adder yields pass=1.
